// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 receiver.
// Optional parity checking is selected with the PS2_PARITY_CHECK_EN macro.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int unsigned PS2_FRAME_BITS     = 11;
    localparam int unsigned PS2_SHIFT_BITS     = PS2_FRAME_BITS - 1;
    localparam int unsigned PS2_CNT_W          = 4;
    localparam int unsigned FILTER_LEN_DEF     = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 50000;

    // Frame payload after the start bit, in arrival order LSB first.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

endpackage

// File: rtl/ps2_filtro_flanco.sv
// Synchronises ps2c/ps2d, deglitches ps2c and emits a one-cycle pulse on
// each filtered falling edge of the PS/2 clock.
module ps2_filtro_flanco
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c_i,
    input  logic ps2d_i,
    output logic fall_o,
    output logic ps2d_o
);

    logic [1:0]            c_sync_q;
    logic [1:0]            d_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  level_q, level_d;
    logic                  fall_q, fall_d;

    // Level changes only once the whole window agrees.
    always_comb begin
        filt_d  = {c_sync_q[1], filt_q[FILTER_LEN-1:1]};
        level_d = level_q;
        if (&filt_q) begin
            level_d = 1'b1;
        end else if (~|filt_q) begin
            level_d = 1'b0;
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= '1;
            level_q  <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c_i};
            d_sync_q <= {d_sync_q[0], ps2d_i};
            filt_q   <= filt_d;
            level_q  <= level_d;
            fall_q   <= fall_d;
        end
    end

    assign fall_o = fall_q;
    assign ps2d_o = d_sync_q[1];

endmodule

// File: rtl/ps2_receptor.sv
// PS/2 keyboard frame receiver with watchdog; presents scan codes on dato/tick.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_receptor
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dato,
    output logic       tick,
    output logic       frame_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                 fall;
    logic                 ps2d_s;
    state_e               state_q, state_d;
    logic [PS2_CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    ps2_frame_t           sh_q, sh_d;
    logic [7:0]           dato_q, dato_d;
    logic                 tick_q, tick_d;
    logic                 err_q, err_d;
    logic                 frame_ok_c;

    ps2_filtro_flanco #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filtro (
        .clk   (clk),
        .rst   (rst),
        .ps2c_i(ps2c),
        .ps2d_i(ps2d),
        .fall_o(fall),
        .ps2d_o(ps2d_s)
    );

    // Next-state and output decode; the frame verdict is issued with the
    // last falling edge so tick/frame_err land in the FIN cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        sh_d       = sh_q;
        dato_d     = dato_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;
        frame_ok_c = 1'b0;

        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (fall && rx_en && !ps2d_s) begin
                    state_d = RECV;
                    cnt_d   = PS2_CNT_W'(PS2_SHIFT_BITS - 1);
                end
            end
            RECV: begin
                if (fall) begin
                    sh_d = ps2_frame_t'({ps2d_s, sh_q[PS2_SHIFT_BITS-1:1]});
                    wd_d = '0;
`ifdef PS2_PARITY_CHECK_EN
                    frame_ok_c = sh_d.stop & (^{sh_d.data, sh_d.parity});
`else
                    frame_ok_c = sh_d.stop;
`endif
                    if (cnt_q == '0) begin
                        state_d = FIN;
                        if (frame_ok_c) begin
                            dato_d = sh_d.data;
                            tick_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - PS2_CNT_W'(1);
                    end
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    wd_d    = '0;
                    cnt_d   = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
                wd_d    = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wd_q    <= '0;
            sh_q    <= '0;
            dato_q  <= 8'h00;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            sh_q    <= sh_d;
            dato_q  <= dato_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign dato      = dato_q;
    assign tick      = tick_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_receptor.sv
// Scoreboard bench for ps2_receptor: a driver builds PS/2 frames and queues the
// expected verdict; a monitor checks every tick/frame_err and dato stability.
module tb_ps2_receptor;

    localparam int unsigned FL   = 8;
    localparam int unsigned TO   = 400;
    localparam int unsigned HALF = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic [7:0] dato;
    logic       tick;
    logic       frame_err;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         errors    = 0;
    int         checks    = 0;
    int         ev_count  = 0;
    logic [7:0] model_dato = 8'h00;
    bit         done      = 1'b0;

    always #5 clk = ~clk;

    ps2_receptor #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2c     (ps2c),
        .ps2d     (ps2d),
        .rx_en    (rx_en),
        .dato     (dato),
        .tick     (tick),
        .frame_err(frame_err)
    );

    // Reference verdict straight from the frame rules.
    function automatic bit frame_good(input logic [7:0] d, input bit par, input bit stop);
        int ones;
        ones = $countones({d, par});
`ifdef PS2_PARITY_CHECK_EN
        return stop && (ones % 2 == 1);
`else
        return stop;
`endif
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input bit b);
        ps2d = b;
        wait_clk(HALF / 2);
        ps2c = 1'b0;
        wait_clk(HALF);
        ps2c = 1'b1;
        wait_clk(HALF / 2);
    endtask

    task automatic glitch();
        ps2c = 1'b0;
        wait_clk(3);
        ps2c = 1'b1;
        wait_clk(20);
    endtask

    // nbits < 11 sends a truncated frame; rx_off_at drops rx_en before that bit.
    task automatic send_frame(input logic [7:0] d, input bit par, input bit stop,
                              input int glitch_at, input bit expect_ev,
                              input int rx_off_at, input int nbits);
        logic [10:0] bits;
        exp_t        e;
        bits = {stop, par, d, 1'b0};
        if (expect_ev) begin
            e.err  = !frame_good(d, par, stop) || (nbits < 11);
            e.data = d;
            q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_at) glitch();
            if (i == rx_off_at) rx_en = 1'b0;
            send_bit(bits[i]);
        end
        ps2d = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events still pending, required 0", name, q.size());
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            if (rst !== 1'b1) begin
                checks++;
                if (dato !== 8'h00 || tick !== 1'b0 || frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL reset: dato=%h tick=%b frame_err=%b, required 00/0/0",
                             dato, tick, frame_err);
                end
            end else begin
                if (tick === 1'b1 && frame_err === 1'b1) begin
                    checks++;
                    errors++;
                    ev_count++;
                    $display("FAIL exclusive: tick and frame_err both high");
                end else if (tick === 1'b1 || frame_err === 1'b1) begin
                    checks++;
                    ev_count++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected: tick=%b frame_err=%b dato=%h, required no event",
                                 tick, frame_err, dato);
                    end else begin
                        mon_e = q.pop_front();
                        if (mon_e.err !== frame_err || (!mon_e.err && dato !== mon_e.data)) begin
                            errors++;
                            $display("FAIL event: frame_err=%b dato=%h, required frame_err=%b dato=%h",
                                     frame_err, dato, mon_e.err, mon_e.err ? model_dato : mon_e.data);
                        end
                        if (!mon_e.err) model_dato = mon_e.data;
                    end
                end
                checks++;
                if (dato !== model_dato) begin
                    errors++;
                    $display("FAIL dato_hold: dato=%h, required %h", dato, model_dato);
                    model_dato = dato;
                end
            end
        end
    end

    initial begin
        int          ev_before;
        logic [7:0]  d;
        bit          par;
        bit          stop;

        rst   = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        wait_clk(10);
        rst = 1'b1;
        wait_clk(30);

        send_frame(8'h1D, 1'b1, 1'b1, -1, 1'b1, -1, 11);
        wait_clk(40);
        send_frame(8'hF0, 1'b1, 1'b1, -1, 1'b1, -1, 11);
        wait_clk(40);
        send_frame(8'h1D, 1'b1, 1'b1, -1, 1'b1, -1, 11);
        wait_clk(40);
        send_frame(8'h1D, 1'b0, 1'b1, -1, 1'b1, -1, 11);
        wait_clk(40);
        send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1, -1, 11);
        wait_clk(40);

        glitch();
        send_frame(8'h1D, 1'b1, 1'b1, 5, 1'b1, -1, 11);
        wait_clk(40);

        send_frame(8'h55, 1'b1, 1'b1, -1, 1'b1, -1, 5);
        wait_clk(TO + 60);
        drain("timeout");
        send_frame(8'h1D, 1'b1, 1'b1, -1, 1'b1, -1, 11);
        drain("after_timeout");

        send_frame(8'h3C, 1'b1, 1'b1, -1, 1'b0, -1, 5);
        @(posedge clk);
        rst        = 1'b0;
        model_dato = 8'h00;
        q.delete();
        wait_clk(20);
        rst = 1'b1;
        wait_clk(20);
        send_frame(8'h1D, 1'b1, 1'b1, -1, 1'b1, -1, 11);
        drain("after_reset");

        ev_before = ev_count;
        rx_en = 1'b0;
        send_frame(8'h1D, 1'b1, 1'b1, -1, 1'b0, -1, 11);
        wait_clk(100);
        rx_en = 1'b1;
        checks++;
        if (ev_count != ev_before) begin
            errors++;
            $display("FAIL rx_en_off: %0d events seen, required 0", ev_count - ev_before);
        end

        send_frame(8'h6B, 1'b0, 1'b1, -1, 1'b1, 3, 11);
        rx_en = 1'b1;
        wait_clk(40);

        for (int k = 0; k < 20; k++) begin
            d    = 8'($urandom);
            par  = ~(^d);
            if ($urandom_range(0, 3) == 0) par = ~par;
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, par, stop, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1,
                       1'b1, -1, 11);
            wait_clk(int'($urandom_range(30, 80)));
        end

        drain("final");
        wait_clk(50);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_receptor.md
# ps2_receptor

Receives serial frames from a PS/2 keyboard on the ps2c/ps2d lines, deglitches the PS/2 clock, assembles each 11-bit frame and presents the 8-bit scan code with a one-cycle strobe. It sits directly upstream of the scan-code activator stage, which consumes `dato` qualified by `tick`. A watchdog discards stalled frames so a dropped bit never desynchronises later codes.

## Interface
Parameters:
- FILTER_LEN, 8: number of consecutive equal ps2c samples required to change the filtered level (range 2..16).
- TIMEOUT_CYCLES, 50000: system clocks allowed between PS/2 falling edges inside a frame before abort (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- ps2c  input  1  PS/2 clock pin, asynchronous to clk.
- ps2d  input  1  PS/2 data pin, asynchronous to clk.
- rx_en  input  1  when 0, no new frame is started; a frame in progress completes.
- dato  output  8  last received scan code; holds until the next good frame.
- tick  output  1  one-cycle strobe: `dato` updated this cycle.
- frame_err  output  1  one-cycle strobe: frame discarded (timeout, bad stop bit, bad parity when enabled).

## Operation
- ps2c and ps2d each pass through a 2-flop synchroniser. Synchronised ps2c feeds a FILTER_LEN-bit shift register; filtered level goes 1 when all bits are 1, 0 when all bits are 0, else holds. A falling edge (`fall`) is a one-cycle pulse when filtered level goes 1→0. ps2d is sampled on `fall`.
- Frame: start(0), d0..d7 LSB first, odd parity, stop(1). Eleven falling edges.
- FSM states:
  - IDLE: on `fall` with rx_en=1 and ps2d=0 → RECV, bit counter=9, watchdog cleared. A `fall` with ps2d=1 is ignored.
  - RECV: each `fall` shifts ps2d into the MSB of a 10-bit register and decrements the counter. `fall` at counter 0 → FIN. Watchdog counts clocks since the last `fall`; reaching TIMEOUT_CYCLES → IDLE with frame_err=1 for one cycle.
  - FIN (one cycle): stop bit=1 and (parity check passes or is compiled out) → `dato`=data bits, tick=1; otherwise frame_err=1 and `dato` unchanged. → IDLE.
- rx_en deasserted mid-frame does not abort.
- Reset (any time, including mid-frame): state IDLE, counter 0, watchdog 0, filter register all 1s, filtered level 1, synchronisers 1, dato=8'h00, tick=0, frame_err=0. The first filtered edge after reset is never a falling edge.

## Timing
- Pin edge to `fall`: 2 (sync) + FILTER_LEN cycles, plus 1 for the level register.
- tick/frame_err rise exactly one clock after the `fall` of the stop bit and last exactly one clock.
- `dato` changes only in the same cycle as tick; stable otherwise.
- tick and frame_err are never high together.
- Watchdog is active only in RECV; it is 0 in IDLE.
- Back-to-back frames: IDLE is re-entered before the next start bit can arrive (≥30 µs), so no start is lost.

## Configuration
- PS2_PARITY_CHECK_EN defined: FIN requires the XOR of d0..d7 and parity to be 1; a failure gives frame_err, no tick.
- Not defined: the parity bit is shifted in and ignored; only the stop bit is checked.

## Structure
- Package ps2_pkg holds the state enum (IDLE, RECV, FIN), PS2_FRAME_BITS=11, and defaults for FILTER_LEN and TIMEOUT_CYCLES.
- Sub-module ps2_filtro_flanco holds the synchronisers, the filter and the falling-edge detector. It outputs `fall` and the synchronised ps2d.

## Test plan
- Frame 0x1D (data 1,0,1,1,1,0,0,0; parity 1; stop 1), ps2c period 80 µs → exactly one tick, dato=8'h1D, frame_err=0.
- 0xF0 then 0x1D back-to-back, 40 µs gap → two ticks in order, dato 8'hF0 then 8'h1D.
- 0x1D with parity bit 0, macro defined → frame_err pulse, no tick, dato unchanged. Macro undefined → tick with dato=8'h1D.
- 3-cycle low glitch on ps2c in IDLE and mid-frame (FILTER_LEN=8) → ignored; frame still decodes as 8'h1D.
- Stop after 5 bits, idle beyond TIMEOUT_CYCLES → single frame_err, FSM in IDLE. Next full 0x1D frame → tick, dato=8'h1D.
- rst low after bit 4, release, send 0x1D → dato=8'h00 during reset, then one tick with dato=8'h1D. Start with rx_en=0 → no reception.
